// File: rtl/axi_lite_master.sv
// =============================================================================
//  Module   : axi_lite_master
//  Brief    : Single-outstanding AXI4-Lite initiator that turns core-side
//             load/store requests into AXI4-Lite read/write transactions.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,

    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,

    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,

    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,

    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP
);

    localparam logic [2:0] c_prot = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_ADDR = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  bready_q,    bready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rready_q,    rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  w_accept;

    assign w_accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (req_we) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // The response only counts once both AW and W have been handed off.
                if (!awvalid_q && !wvalid_q && bready_q && M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (M_AXI_BRESP != 2'b00);
                    state_d     = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_err_d   = (M_AXI_RRESP != 2'b00);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = c_prot;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = c_prot;
    assign M_AXI_RREADY  = rready_q;

endmodule

`default_nettype wire
